icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Sequencing controller for the direct-mapped instruction cache. It owns the tag-RAM and data-RAM ports, performs hit/miss lookup for fetch requests, refills one line from memory over a req/ack handshake, and runs a whole-cache flush.
- Sits between the IF stage and the instruction memory bus.
- Line = one 32-bit word.

Parameters:
- ADDR_W, 32, fetch address width.
- INDEX_W, 6, cache index bits; number of lines is 2**INDEX_W.
- OFFSET_W, 2, byte-offset bits. These are ignored for lookup and forced to 0 on mem_addr.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  fetch request. Held with cpu_addr stable until cpu_ready.
- cpu_addr  in  ADDR_W  fetch byte address.
- cpu_ready  out  1  cpu_inst valid this cycle; completes the request.
- cpu_inst  out  32  fetched instruction.
- flush  in  1  one-cycle flush request pulse.
- flush_busy  out  1  flush walk in progress.
- mem_req  out  1  refill request, held until mem_ack.
- mem_addr  out  ADDR_W  refill word address, stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in that cycle.
- mem_data  in  32  refill word.
- tag_we  out  1  tag RAM write enable.
- tag_index  out  INDEX_W  tag RAM index.
- tag_valid_in  out  1  valid bit written.
- tag_in  out  ADDR_W-INDEX_W-OFFSET_W  tag written.
- tag_valid_out  in  1  asynchronous-read valid bit.
- tag_out  in  ADDR_W-INDEX_W-OFFSET_W  asynchronous-read tag.
- data_we  out  1  data RAM write enable.
- data_index  out  INDEX_W  data RAM index.
- data_in  out  32  data written.
- data_out  in  32  asynchronous-read data.

Behaviour:
- Field extraction:
  - idx = cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W]
  - tag = cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W]
  - hit = tag_valid_out && (tag_out == tag)
- States: FLUSH, IDLE, MISS, REFILL.
- Reset:
  - Next state is FLUSH with flush counter 0.
  - mem_req=0, cpu_ready=0, tag_we=0, data_we=0, flush_busy=1 from the cycle after reset.
  - Reset mid-miss abandons the request. A later mem_ack is ignored.
- FLUSH:
  - Each cycle: tag_we=1, tag_index=counter, tag_valid_in=0, tag_in=0.
  - Counter increments each cycle; takes 2**INDEX_W cycles.
  - Goes to IDLE after writing index 2**INDEX_W-1, where flush_busy drops.
  - cpu_ready=0 throughout. flush pulses during FLUSH are ignored.
- IDLE:
  - tag_index and data_index are driven combinationally from idx.
  - flush has priority over cpu_req and enters FLUSH next cycle.
  - Else, cpu_req && hit: cpu_ready=1 and cpu_inst=data_out in the same cycle (zero-wait hit).
  - Else, cpu_req && !hit: latch {tag, idx} and enter MISS.
- MISS:
  - mem_req=1 and mem_addr={latched tag, latched idx, OFFSET_W'b0}.
  - On mem_ack: latch mem_data and enter REFILL.
  - A flush pulse arriving here is recorded as pending; the refill completes first.
- REFILL:
  - One cycle: tag_we=1, data_we=1 at the latched index, tag_valid_in=1, tag_in=latched tag, data_in=latched data.
  - Next state: FLUSH if a flush is pending, else IDLE, where the retried lookup hits.
- Miss latency with ack in the first MISS cycle: lookup cycle 0, MISS cycle 1, REFILL cycle 2, cpu_ready in cycle 3.
- mem_ack outside MISS is ignored.
- cpu_addr offset bits never affect lookup.
- A conflicting index overwrites the resident line (direct-mapped, no victim logic).

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, two extra outputs exist: hit_count[31:0] and miss_count[31:0]. Both are saturating counters, zeroed on reset.
  - miss_count +1 on each IDLE to MISS transition.
  - hit_count +1 on each cpu_ready, except the first ready following a REFILL. A replay flag set in REFILL and cleared on ready identifies that case.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- icache_pkg holds:
  - the state enum typedef (FLUSH, IDLE, MISS, REFILL);
  - functions returning index and tag fields from an address;
  - the tag-width localparam derivation.
- Sub-module icache_stats (two saturating counters plus replay flag) is instantiated only under ICACHE_STATS_EN.
- The FSM and flush counter stay in icache_ctrl.

Test Plan:
- Reset, then hold cpu_req with cpu_addr=0x104 -> flush_busy high for 64 cycles writing valid=0 at indices 0..63; cpu_ready stays 0 until the flush ends.
- Cold miss on 0x104 -> mem_req with mem_addr=0x104; ack with data 0xDEADBEEF -> REFILL writes index 1, tag 1, valid 1; cpu_ready with cpu_inst=0xDEADBEEF three cycles after lookup.
- Repeat fetch of 0x106 after the fill -> same-cycle cpu_ready, 0xDEADBEEF, no mem_req.
- Conflict fetch of 0x204 (index 1, tag 2) with ack data 0x12345678 -> line replaced; a later fetch of 0x104 misses again.
- Flush pulse while in MISS with mem_ack delayed 5 cycles -> refill completes, then a 64-cycle flush; the next fetch of 0x104 misses.
- ICACHE_STATS_EN build: cold miss then two hits on 0x104 -> miss_count=1, hit_count=2.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and helpers for the direct-mapped instruction cache controller.
//   state_t     : controller sequencing states
//   tag_width   : derives the tag field width from address/index/offset widths
//   addr_index  : extracts the line index field from a (zero-extended) address
//   addr_tag    : extracts the tag field from a (zero-extended) address
// Helpers operate on MAX_ADDR_W-bit values; callers size-cast the result.
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    S_FLUSH  = 2'd0,
    S_IDLE   = 2'd1,
    S_MISS   = 2'd2,
    S_REFILL = 2'd3
  } state_t;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int index_w, input int offset_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (64'd1 << index_w) - 64'd1;
    return (addr >> offset_w) & mask;
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int index_w, input int offset_w);
    return addr >> (index_w + offset_w);
  endfunction

endpackage

// File: rtl/icache_stats.sv
// -----------------------------------------------------------------------------
// icache_stats
// Saturating hit/miss counters for the instruction cache controller.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   ready          : a fetch completed this cycle
//   miss_start     : controller moves from lookup into a miss this cycle
//   refill         : controller is writing a refilled line this cycle
//   hit_count      : completed fetches that were genuine hits
//   miss_count     : lookups that missed
// The first ready after a refill is the replayed lookup of the missing fetch,
// so it is not counted as a hit.
// -----------------------------------------------------------------------------
module icache_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        miss_start,
  input  logic        refill,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  logic replay_r;

  // Counter and replay-flag update
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
      replay_r   <= 1'b0;
    end else begin
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
      if (ready && !replay_r && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (refill) begin
        replay_r <= 1'b1;
      end else if (ready) begin
        replay_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Sequencing controller for a direct-mapped instruction cache (one 32-bit word
// per line). Performs zero-wait hit lookup, single-word refill over a req/ack
// memory handshake, and a whole-cache flush walk (also run out of reset).
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   cpu_req/cpu_addr             : fetch request, held until cpu_ready
//   cpu_ready/cpu_inst           : fetch completion and instruction
//   flush/flush_busy             : flush pulse and walk-in-progress flag
//   mem_req/mem_addr             : refill request (held until mem_ack)
//   mem_ack/mem_data             : refill response pulse and word
//   tag_* / data_*               : tag and data RAM ports (asynchronous read)
// Optional feature (macro ICACHE_STATS_EN): adds hit_count and miss_count
// outputs driven by the icache_stats sub-module.
// -----------------------------------------------------------------------------
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = tag_width(ADDR_W, INDEX_W, OFFSET_W)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic [31:0]        cpu_inst,
  input  logic               flush,
  output logic               flush_busy,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_data,
  output logic               tag_we,
  output logic [INDEX_W-1:0] tag_index,
  output logic               tag_valid_in,
  output logic [TAG_W-1:0]   tag_in,
  input  logic               tag_valid_out,
  input  logic [TAG_W-1:0]   tag_out,
  output logic               data_we,
  output logic [INDEX_W-1:0] data_index,
  output logic [31:0]        data_in,
  input  logic [31:0]        data_out
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  state_t             state_r;
  state_t             next_s;
  logic [INDEX_W-1:0] flush_cnt_r;
  logic               flush_pend_r;
  logic [TAG_W-1:0]   miss_tag_r;
  logic [INDEX_W-1:0] miss_idx_r;
  logic [31:0]        fill_data_r;

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit_s;
  logic               miss_start_s;

  // Offset bits are dropped by the field helpers, so they never influence lookup
  assign idx_s        = INDEX_W'(addr_index(MAX_ADDR_W'(cpu_addr), INDEX_W, OFFSET_W));
  assign tag_s        = TAG_W'(addr_tag(MAX_ADDR_W'(cpu_addr), INDEX_W, OFFSET_W));
  assign hit_s        = tag_valid_out && (tag_out == tag_s);
  assign miss_start_s = (state_r == S_IDLE) && (next_s == S_MISS);

  // State register, flush walk counter and miss bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_FLUSH;
      flush_cnt_r  <= {INDEX_W{1'b0}};
      flush_pend_r <= 1'b0;
      miss_tag_r   <= {TAG_W{1'b0}};
      miss_idx_r   <= {INDEX_W{1'b0}};
      fill_data_r  <= 32'h0;
    end else begin
      state_r <= next_s;
      // Counter restarts at zero whenever a walk is entered
      if (state_r == S_FLUSH) begin
        flush_cnt_r <= flush_cnt_r + INDEX_W'(1'b1);
      end else begin
        flush_cnt_r <= {INDEX_W{1'b0}};
      end
      if (miss_start_s) begin
        miss_tag_r <= tag_s;
        miss_idx_r <= idx_s;
      end
      if ((state_r == S_MISS) && mem_ack) begin
        fill_data_r <= mem_data;
      end
      // A flush during an outstanding refill waits until the line is written
      if (((state_r == S_MISS) || (state_r == S_REFILL)) && flush) begin
        flush_pend_r <= 1'b1;
      end else if (state_r == S_FLUSH) begin
        flush_pend_r <= 1'b0;
      end
    end
  end

  // Next-state and RAM/bus output decode
  always_comb begin
    next_s       = state_r;
    cpu_ready    = 1'b0;
    cpu_inst     = 32'h0;
    flush_busy   = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = {miss_tag_r, miss_idx_r, {OFFSET_W{1'b0}}};
    tag_we       = 1'b0;
    tag_index    = idx_s;
    tag_valid_in = 1'b0;
    tag_in       = {TAG_W{1'b0}};
    data_we      = 1'b0;
    data_index   = idx_s;
    data_in      = fill_data_r;
    case (state_r)
      S_FLUSH: begin
        flush_busy = 1'b1;
        tag_we     = 1'b1;
        tag_index  = flush_cnt_r;
        if (flush_cnt_r == {INDEX_W{1'b1}}) begin
          next_s = S_IDLE;
        end else begin
          next_s = S_FLUSH;
        end
      end
      S_IDLE: begin
        if (flush) begin
          next_s = S_FLUSH;
        end else if (cpu_req && hit_s) begin
          cpu_ready = 1'b1;
          cpu_inst  = data_out;
          next_s    = S_IDLE;
        end else if (cpu_req) begin
          next_s = S_MISS;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_MISS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          next_s = S_REFILL;
        end else begin
          next_s = S_MISS;
        end
      end
      S_REFILL: begin
        tag_we       = 1'b1;
        data_we      = 1'b1;
        tag_index    = miss_idx_r;
        data_index   = miss_idx_r;
        tag_valid_in = 1'b1;
        tag_in       = miss_tag_r;
        if (flush_pend_r || flush) begin
          next_s = S_FLUSH;
        end else begin
          next_s = S_IDLE;
        end
      end
      default: begin
        next_s = S_FLUSH;
      end
    endcase
  end

`ifdef ICACHE_STATS_EN
  icache_stats u_stats (
    .clock      (clock),
    .reset      (reset),
    .ready      (cpu_ready),
    .miss_start (miss_start_s),
    .refill     (state_r == S_REFILL),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
// Scoreboard bench for icache_ctrl with behavioural tag/data RAMs and a
// memory responder. Expected instructions and expected refill transactions are
// queued by the stimulus; monitors pop and compare when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_inst;
  logic        flush;
  logic        flush_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        tag_we;
  logic [5:0]  tag_index;
  logic        tag_valid_in;
  logic [23:0] tag_in;
  logic        tag_valid_out;
  logic [23:0] tag_out;
  logic        data_we;
  logic [5:0]  data_index;
  logic [31:0] data_in;
  logic [31:0] data_out;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clock = ~clock;

  icache_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_ready     (cpu_ready),
    .cpu_inst      (cpu_inst),
    .flush         (flush),
    .flush_busy    (flush_busy),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .tag_we        (tag_we),
    .tag_index     (tag_index),
    .tag_valid_in  (tag_valid_in),
    .tag_in        (tag_in),
    .tag_valid_out (tag_valid_out),
    .tag_out       (tag_out),
    .data_we       (data_we),
    .data_index    (data_index),
    .data_in       (data_in),
    .data_out      (data_out)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // Behavioural RAMs: synchronous write, asynchronous read
  logic        vmem [64];
  logic [23:0] tmem [64];
  logic [31:0] dmem [64];

  always @(posedge clock) begin
    if (tag_we) begin
      vmem[tag_index] <= tag_valid_in;
      tmem[tag_index] <= tag_in;
    end
    if (data_we) begin
      dmem[data_index] <= data_in;
    end
  end

  assign tag_valid_out = vmem[tag_index];
  assign tag_out       = tmem[tag_index];
  assign data_out      = dmem[data_index];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  mem_t        rsp;

  int checks     = 0;
  int failures   = 0;
  bit run_en     = 1'b0;
  int fl_idx     = 0;
  int flush_runs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic [31:0] addr, input logic [31:0] data, input int delay);
    mem_t e;
    e.addr  = addr;
    e.data  = data;
    e.delay = delay;
    mem_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] exp_inst);
    exp_q.push_back(exp_inst);
    cpu_req  = 1'b1;
    cpu_addr = addr;
  endtask

  // Latency = number of non-flush cycles before the ready cycle
  task automatic wait_ready(input string name, input int exp_lat);
    int k;
    bit got;
    k   = 0;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (cpu_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (flush_busy !== 1'b1) k++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready expected=ready", name);
    end else begin
      check({name, "_latency"}, 64'(k), 64'(exp_lat));
      if (exp_lat == 0) check({name, "_no_mem_req"}, 64'(mem_req), 64'd0);
    end
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp_inst,
                       input int exp_lat);
    issue(addr, exp_inst);
    wait_ready(name, exp_lat);
  endtask

  // Instruction scoreboard monitor
  always @(negedge clock) begin
    if (run_en && (cpu_ready === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=0x%0h expected=none", cpu_inst);
      end else begin
        mon_exp = exp_q.pop_front();
        check("cpu_inst", 64'(cpu_inst), 64'(mon_exp));
      end
    end
  end

  // Flush walk monitor: sequential invalidating writes, no ready, 64 cycles long
  always @(negedge clock) begin
    if (run_en) begin
      if (flush_busy === 1'b1) begin
        check("flush_write", 64'({tag_we, tag_valid_in, tag_index, cpu_ready}),
              64'({1'b1, 1'b0, fl_idx[5:0], 1'b0}));
        fl_idx++;
      end else if (fl_idx != 0) begin
        check("flush_len", 64'(fl_idx), 64'd64);
        flush_runs++;
        fl_idx = 0;
      end
    end
  end

  // Memory responder: checks each refill request and the refill write it causes
  initial begin
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    forever begin
      @(negedge clock);
      if (run_en && (mem_req === 1'b1)) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req actual=0x%0h expected=none", mem_addr);
        end else begin
          rsp = mem_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(rsp.addr));
          for (int d = 0; d < rsp.delay; d++) @(negedge clock);
          check("mem_addr_stable", 64'({mem_req, mem_addr}), 64'({1'b1, rsp.addr}));
          mem_ack  = 1'b1;
          mem_data = rsp.data;
          @(negedge clock);
          mem_ack  = 1'b0;
          mem_data = 32'h0;
          check("refill_ctrl", 64'({data_we, tag_we, tag_valid_in, tag_index, data_index}),
                64'({1'b1, 1'b1, 1'b1, rsp.addr[7:2], rsp.addr[7:2]}));
          check("refill_tag_data", 64'({tag_in, data_in}), 64'({rsp.addr[31:8], rsp.data}));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = 32'h0;
    flush    = 1'b0;
    // Stale contents that would falsely hit 0x104 if the reset flush were skipped
    for (int i = 0; i < 64; i++) begin
      vmem[i] = 1'b1;
      tmem[i] = 24'h1;
      dmem[i] = 32'h5A5A_0000 + 32'(i);
    end

    // Cold miss on 0x104, request held through reset and the flush walk
    push_mem(32'h0000_0104, 32'hDEAD_BEEF, 0);
    issue(32'h0000_0104, 32'hDEAD_BEEF);
    @(posedge clock);
    @(negedge clock);
    check("reset_outputs", 64'({flush_busy, mem_req, cpu_ready, data_we}), 64'(4'b1000));
    @(posedge clock);
    #1;
    reset  = 1'b0;
    run_en = 1'b1;
    wait_ready("cold_miss", 3);
    check("flush_runs_reset", 64'(flush_runs), 64'd1);

    // Hits, including one with non-zero offset bits
    fetch("hit_offset", 32'h0000_0106, 32'hDEAD_BEEF, 0);
    fetch("hit_repeat", 32'h0000_0104, 32'hDEAD_BEEF, 0);
`ifdef ICACHE_STATS_EN
    check("miss_count_1", 64'(miss_count), 64'd1);
    check("hit_count_2", 64'(hit_count), 64'd2);
`endif

    // Conflicting tag on index 1 replaces the line
    push_mem(32'h0000_0204, 32'h1234_5678, 0);
    fetch("conflict_miss", 32'h0000_0204, 32'h1234_5678, 3);

    // Stray mem_ack in IDLE must be ignored
    mem_ack  = 1'b1;
    mem_data = 32'hBAD0_BAD0;
    @(posedge clock);
    #1;
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    fetch("stray_ack_hit", 32'h0000_0204, 32'h1234_5678, 0);

    // 0x104 now misses; flush arrives mid-miss with a 5-cycle late ack.
    // The refill completes, the flush walks, and the held fetch misses again.
    push_mem(32'h0000_0104, 32'hCAFE_F00D, 5);
    push_mem(32'h0000_0104, 32'hCAFE_F00D, 0);
    fork
      fetch("flush_in_miss", 32'h0000_0104, 32'hCAFE_F00D, 11);
      begin
        @(posedge clock);
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
      end
    join
    check("flush_runs_pending", 64'(flush_runs), 64'd2);

    repeat (2) @(posedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
`ifdef ICACHE_STATS_EN
    check("miss_count_final", 64'(miss_count), 64'd4);
    check("hit_count_final", 64'(hit_count), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
